// File: rtl/range_sample_writer.sv
// Capture stage: tags 16-bit samples with a sequence number and writes them into a RAM circular buffer.
// Optional RANGE_WRITER_TIMESTAMP_EN precedes each sample word with a 32-bit cycle timestamp.
module range_sample_writer #(
    parameter int ADDR_W      = 15,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH_WORDS = 32768,
    parameter int HALF_WORDS  = 16384
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              snk_valid,
    output logic              snk_ready,
    input  logic [15:0]       snk_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped,
    output logic              wm_irq,
    input  logic              irq_ack,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, WR, WR_TS} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(HALF_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [15:0]       seq;
    logic              stop_pend, restart_pend;
    logic              accept, wr_done, wr_issue, clr;
    logic              stop_eff, restart_eff;

    assign snk_ready = (state == RUN) && !stop && !start;
    assign accept    = snk_valid && snk_ready;
    assign busy      = (state != IDLE);
    assign wr_ptr    = ptr;
    assign wr_done   = (state == WR) || (state == WR_TS);

    // A stop after a start (or pending restart) is a stop; a start after a stop is a restart.
    assign stop_eff    = stop || stop_pend;
    assign restart_eff = !stop && (start || restart_pend);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        case (state)
            IDLE: if (start && !stop) begin
                state_nxt = RUN;
                clr       = 1'b1;
            end
            RUN: begin
                if (stop) state_nxt = IDLE;
                else if (start) clr = 1'b1;
                else if (accept) begin
`ifdef RANGE_WRITER_TIMESTAMP_EN
                    state_nxt = WR_TS;
`else
                    state_nxt = WR;
`endif
                end
            end
            WR_TS: state_nxt = WR;
            WR: begin
                if (restart_eff) begin
                    state_nxt = RUN;
                    clr       = 1'b1;
                end else if (stop_eff) state_nxt = IDLE;
                else state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt = ptr;
        if (wr_done) ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
        if (clr) ptr_nxt = '0;
    end

    assign wr_issue = (state_nxt == WR) || (state_nxt == WR_TS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= '0;
            seq            <= '0;
            wrapped        <= 1'b0;
            wm_irq         <= 1'b0;
            stop_pend      <= 1'b0;
            restart_pend   <= 1'b0;
            ram_write      <= 1'b0;
            ram_chipselect <= 1'b0;
            ram_byteenable <= 4'h0;
            ram_address    <= '0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            ram_write      <= wr_issue;
            ram_chipselect <= wr_issue;
            ram_byteenable <= wr_issue ? 4'hF : 4'h0;
            if (wr_issue) ram_address <= BASE + ptr_nxt;
            if (clr) seq <= '0;
            else if (accept) seq <= seq + 16'd1;
            if (clr) wrapped <= 1'b0;
            else if (wr_done && ptr == LAST) wrapped <= 1'b1;
            // Set beats a same-cycle acknowledge.
            if (wr_done && (ptr == HALF || ptr == LAST)) wm_irq <= 1'b1;
            else if (irq_ack) wm_irq <= 1'b0;
            if (state == WR_TS) begin
                stop_pend    <= stop || (stop_pend && !start);
                restart_pend <= restart_eff;
            end else begin
                stop_pend    <= 1'b0;
                restart_pend <= 1'b0;
            end
        end
    end

`ifdef RANGE_WRITER_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] data_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt        <= '0;
            data_hold     <= '0;
            ram_writedata <= '0;
        end else begin
            ts_cnt <= clr ? 32'd0 : ts_cnt + 32'd1;
            if (accept) begin
                ram_writedata <= ts_cnt;
                data_hold     <= {seq, snk_data};
            end else if (state == WR_TS) begin
                ram_writedata <= data_hold;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ram_writedata <= '0;
        else if (accept) ram_writedata <= {seq, snk_data};
    end
`endif
endmodule
